// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: round-robin arbiter from NUM_PORTS request FIFOs onto one
// registered L2 request channel. Each forwarded word carries its port index in
// out_id so the response path can steer data back to the requester.
// Optional build macro L2_ARB_LOCK_EN: a popped word with bit REQ_WIDTH-1 set
// pins arbitration to that port until a word from it arrives with the bit clear.
module l2_request_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int REQ_WIDTH = 64,
  parameter int ID_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           req_valid,
  input  logic [NUM_PORTS*REQ_WIDTH-1:0] req_data,
  output logic [NUM_PORTS-1:0]           req_pop,
  output logic                           out_valid,
  output logic [REQ_WIDTH-1:0]           out_data,
  output logic [ID_WIDTH-1:0]            out_id,
  input  logic                           out_ready
);

  logic                 load;
  logic                 grant_any;
  logic [ID_WIDTH-1:0]  grant_idx;
  logic [ID_WIDTH-1:0]  last_grant;
  logic [ID_WIDTH-1:0]  scan_id;
  logic [NUM_PORTS-1:0] eligible;
  logic [REQ_WIDTH-1:0] sel_data;

  // The output stage can take a new word when empty or being drained this cycle.
  assign load = ~out_valid | out_ready;

`ifdef L2_ARB_LOCK_EN
  typedef enum logic {ST_IDLE, ST_LOCKED} lock_state_t;
  lock_state_t         lock_state;
  logic [ID_WIDTH-1:0] lock_port;

  // While locked, only the owning port competes for the grant.
  always_comb begin
    eligible = req_valid;
    if (lock_state == ST_LOCKED) begin
      eligible            = '0;
      eligible[lock_port] = req_valid[lock_port];
    end
  end
`else
  assign eligible = req_valid;
`endif

  // Search upward from the port after the last grant, wrapping around.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_id   = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      scan_id = ID_WIDTH'((32'(last_grant) + k + 1) % NUM_PORTS);
      if (!grant_any && eligible[scan_id]) begin
        grant_any = 1'b1;
        grant_idx = scan_id;
      end
    end
  end

  // Head word of the granted port.
  assign sel_data = req_data[grant_idx*REQ_WIDTH +: REQ_WIDTH];

  // Pop strobe: only when the output stage can load and a port is granted.
  always_comb begin
    req_pop = '0;
    if (!rst && load && grant_any) req_pop[grant_idx] = 1'b1;
  end

  // Output register, round-robin pointer and (optionally) lock state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      last_grant <= ID_WIDTH'(NUM_PORTS - 1);
`ifdef L2_ARB_LOCK_EN
      lock_state <= ST_IDLE;
      lock_port  <= '0;
`endif
    end else if (load) begin
      if (grant_any) begin
        out_valid  <= 1'b1;
        out_data   <= sel_data;
        out_id     <= grant_idx;
        last_grant <= grant_idx;
`ifdef L2_ARB_LOCK_EN
        // Every pop re-evaluates the lock from the popped word's lock bit.
        lock_state <= sel_data[REQ_WIDTH-1] ? ST_LOCKED : ST_IDLE;
        lock_port  <= grant_idx;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/l2_request_arbiter.md
Name: l2_request_arbiter

Overview:
- Round-robin arbiter between per-port L2 request FIFOs and the single L2 memory request channel.
- Watches each port FIFO's valid and selects one port per cycle.
- Pops the selected FIFO and registers the request, tagged with its port ID, into one output stage with a valid/ready handshake.
- The ID travels downstream so responses can be routed back to the requesting port.

Parameters:
- NUM_PORTS, 4, number of requesting ports (1..8).
- REQ_WIDTH, 64, width of one opaque request word; bit REQ_WIDTH-1 is the lock flag, used only with L2_ARB_LOCK_EN.
- ID_WIDTH, derived: $clog2(NUM_PORTS) when NUM_PORTS>1, otherwise 1.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_PORTS  per-port FIFO non-empty (FIFO valid).
- req_data  in  NUM_PORTS*REQ_WIDTH  per-port FIFO head word; port i at [i*REQ_WIDTH +: REQ_WIDTH].
- req_pop  out  NUM_PORTS  one-hot (or zero) pop strobe to the port FIFOs; combinational.
- out_valid  out  1  output register holds a request.
- out_data  out  REQ_WIDTH  registered request word.
- out_id  out  ID_WIDTH  port index of out_data.
- out_ready  in  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (synchronous, active-high):
  - out_valid=0, out_data=0, out_id=0.
  - Round-robin pointer last_grant=NUM_PORTS-1, so port 0 has top priority after reset.
  - Lock state cleared.
  - req_pop=0 while rst=1.
- Load condition: load = ~out_valid | out_ready.
- Pop rule:
  - When load=1 and any req_valid=1, exactly one req_pop bit is asserted, for the granted port g.
  - req_pop is never asserted for a port with req_valid=0.
  - req_pop is never asserted when load=0.
- Grant selection: first port with req_valid set, searching upward from (last_grant+1) mod NUM_PORTS with wrap-around.
- On a pop, at the next clock edge:
  - out_data <= req_data[g].
  - out_id <= g.
  - out_valid <= 1.
  - last_grant <= g.
- If load=1 and no req_valid: out_valid <= 0; out_data/out_id hold their values; last_grant unchanged.
- If load=0: all registers hold.
- Latency and throughput:
  - FIFO head to out_valid: 1 cycle.
  - Sustained 1 request/cycle while out_ready=1.
  - Accept and reload happen in the same cycle with no bubble.
- Fairness: with all ports continuously valid, grants rotate 0,1,..,N-1,0,...; no port waits more than NUM_PORTS-1 grants.
- Back-pressure: out_valid=1 with out_ready=0 holds out_data/out_id stable and pops nothing.
- NUM_PORTS=1: pointer logic degenerates; out_id is always 0; req_pop[0] = load & req_valid[0].
- Reset mid-operation: any pending out_valid is dropped. Those words were already popped and are lost; upstream FIFOs are reset together with this block.
- Pure function of clk/rst; no combinational path from out_ready to out_data.

Optional Feature:
- Macro: L2_ARB_LOCK_EN.
- Defined:
  - When a popped request has its lock bit (bit REQ_WIDTH-1) set, the arbiter enters LOCKED on port g.
  - In LOCKED, only port g may be granted; other ports are not popped even when valid.
  - LOCKED exits (back to IDLE round-robin) after popping a request from g whose lock bit is 0.
  - While LOCKED with req_valid[g]=0, no pop occurs and out_valid drops after the current word is accepted.
  - Reset returns to IDLE.
  - last_grant is updated normally, so round-robin resumes at g+1.
- Undefined: lock bit is carried through as ordinary data; no lock state exists.

Test Plan:
- Reset, then all 4 ports valid, out_ready=1, data = 0x10+i → out_id sequence 0,1,2,3,0 on consecutive cycles; out_valid=1 from cycle 1; exactly one req_pop per cycle.
- Only port 2 valid for 3 cycles, out_ready=1 → out_id=2 three times, req_pop=4'b0100 each cycle, no bubbles.
- Port 1 popped, then out_ready=0 for 5 cycles with ports 0 and 3 valid → out_data/out_id frozen at port 1's word and req_pop=0. After out_ready=1, next grant is port 3, then port 0.
- Ports 0 and 1 valid, last_grant=3 → port 0 granted. With last_grant=0 → port 1 granted (wrap-around check).
- rst asserted while out_valid=1 and ports valid → next cycle out_valid=0, req_pop=0. After release, first grant is port 0.
- With L2_ARB_LOCK_EN: port 1 pushes lock=1, lock=1, lock=0 while port 0 is continuously valid → out_id 1,1,1, then 0. With port 1 gapped one cycle mid-lock → out_valid=0 for that cycle and port 0 is not popped.
